ex_stage: RTL and testbench

Execute stage of the pipelined MIPS CPU, sitting between the ID/EX register and the MEM stage. It resolves operand forwarding, runs the single-cycle ALU and a 32-cycle iterative multiply/divide unit that owns the HI/LO registers, and registers the result into the EX/MEM boundary. Its registered outputs are exactly the M-suffixed control and data inputs that the MEM stage consumes. It raises a stall to the hazard unit while a HI/LO access must wait.

---
 rtl/mips_pkg.sv | 46 ++++
 rtl/ex_stage_muldiv_unit.sv | 102 ++++++++++
 rtl/ex_stage.sv | 104 ++++++++++
 tb/tb_ex_stage.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS execute stage: ALU ops, mul/div ops,
// forward selects and the mul/div sequencer states.
package mips_pkg;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_XOR  = 3'b011;
  localparam logic [2:0] ALU_NOR  = 3'b100;
  localparam logic [2:0] ALU_SLTU = 3'b101;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;

  localparam logic [2:0] MD_NONE  = 3'b000;
  localparam logic [2:0] MD_MULT  = 3'b001;
  localparam logic [2:0] MD_MULTU = 3'b010;
  localparam logic [2:0] MD_DIV   = 3'b011;
  localparam logic [2:0] MD_DIVU  = 3'b100;
  localparam logic [2:0] MD_MFHI  = 3'b101;
  localparam logic [2:0] MD_MFLO  = 3'b110;

  localparam logic [1:0] FWD_RD   = 2'b00;
  localparam logic [1:0] FWD_RESW = 2'b01;
  localparam logic [1:0] FWD_ALUM = 2'b10;

  typedef enum logic [1:0] {MD_IDLE, MD_RUN, MD_DONE} md_state_e;

  function automatic logic is_md_arith(input logic [2:0] op);
    return op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
  endfunction

  function automatic logic is_md_any(input logic [2:0] op);
    return op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MFHI, MD_MFLO};
  endfunction

  // Code 11 is unused and falls back to the register-file value.
  function automatic logic [31:0] fwd_sel(input logic [1:0] sel, input logic [31:0] rd,
                                          input logic [31:0] res_w, input logic [31:0] alu_m);
    case (sel)
      FWD_RESW: return res_w;
      FWD_ALUM: return alu_m;
      default:  return rd;
    endcase
  endfunction

endpackage

// File: rtl/ex_stage_muldiv_unit.sv
// Iterative 32-step multiply/divide on operand magnitudes, signs fixed in DONE.
// Owns HI/LO; start is only honoured in IDLE, busy covers RUN and DONE.
module muldiv_unit
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  md_state_e   r_state, w_next;
  logic [4:0]  r_cnt;
  logic [63:0] r_acc;
  logic [2:0]  r_op;
  logic [31:0] r_a, r_b, r_hi, r_lo;

  logic        w_signed, w_is_div, w_a_neg, w_b_neg, w_in_signed;
  logic [31:0] w_mag_b, w_in_mag_a;
  logic [32:0] w_madd, w_dsh, w_dsub;
  logic [63:0] w_step, w_prod;
  logic [31:0] w_quo, w_rem;

  assign w_signed    = (r_op == MD_MULT) || (r_op == MD_DIV);
  assign w_is_div    = (r_op == MD_DIV)  || (r_op == MD_DIVU);
  assign w_a_neg     = w_signed & r_a[31];
  assign w_b_neg     = w_signed & r_b[31];
  assign w_mag_b     = w_b_neg ? -r_b : r_b;
  assign w_in_signed = (op == MD_MULT) || (op == MD_DIV);
  assign w_in_mag_a  = (w_in_signed && a[31]) ? -a : a;

  // Multiply: upper half accumulates, multiplier shifts out of the bottom.
  // Divide: restoring, quotient bits shift into the bottom.
  assign w_madd = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, w_mag_b} : 33'd0);
  assign w_dsh  = {r_acc[63:32], r_acc[31]};
  assign w_dsub = w_dsh - {1'b0, w_mag_b};
  assign w_step = w_is_div ? (w_dsub[32] ? {w_dsh[31:0], r_acc[30:0], 1'b0}
                                         : {w_dsub[31:0], r_acc[30:0], 1'b1})
                           : {w_madd, r_acc[31:1]};

  assign w_prod = (w_a_neg ^ w_b_neg) ? -r_acc : r_acc;
  assign w_quo  = (w_a_neg ^ w_b_neg) ? -r_acc[31:0] : r_acc[31:0];
  assign w_rem  = w_a_neg ? -r_acc[63:32] : r_acc[63:32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= MD_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      MD_IDLE: if (start) w_next = MD_RUN;
      MD_RUN:  if (r_cnt == 5'd31) w_next = MD_DONE;
      MD_DONE: w_next = MD_IDLE;
      default: w_next = MD_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != MD_IDLE);
    hi   = r_hi;
    lo   = r_lo;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_acc <= '0;
      r_op  <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
    end else if (r_state == MD_IDLE && start) begin
      r_op  <= op;
      r_a   <= a;
      r_b   <= b;
      r_acc <= {32'd0, w_in_mag_a};
      r_cnt <= '0;
    end else if (r_state == MD_RUN) begin
      r_acc <= w_step;
      r_cnt <= r_cnt + 5'd1;
    end else if (r_state == MD_DONE) begin
      if (w_is_div && r_b == 32'd0) begin
        r_hi <= r_a;
        r_lo <= 32'hFFFF_FFFF;
      end else if (w_is_div) begin
        r_hi <= w_rem;
        r_lo <= w_quo;
      end else begin
        {r_hi, r_lo} <= w_prod;
      end
    end
  end

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: forwarding, ALU, HI/LO moves, stall logic, EX/MEM register.
// Stalls and flushes both send a bubble (all write enables low) into MEM.
module ex_stage
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RegWriteE,
  input  logic        MemtoRegE,
  input  logic        MemWriteE,
  input  logic [2:0]  ALUControlE,
  input  logic        ALUSrcE,
  input  logic        RegDstE,
  input  logic [2:0]  MulDivE,
  input  logic [4:0]  RtE,
  input  logic [4:0]  RdE,
  input  logic [31:0] RD1E,
  input  logic [31:0] RD2E,
  input  logic [31:0] SignImmE,
  input  logic [1:0]  ForwardAE,
  input  logic [1:0]  ForwardBE,
  input  logic [31:0] ResultW,
  input  logic        FlushE,
  output logic        RegWriteM,
  output logic        MemtoRegM,
  output logic        MemWriteM,
  output logic [4:0]  WriteRegM,
  output logic [31:0] ALUOutM,
  output logic [31:0] WriteDataM,
  output logic        StallE
);

  logic        r_reg_write_m, r_memto_reg_m, r_mem_write_m;
  logic [4:0]  r_write_reg_m;
  logic [31:0] r_alu_out_m, r_write_data_m;

  logic [31:0] w_src_a, w_src_b, w_write_data, w_alu, w_result, w_hi, w_lo;
  logic        w_busy, w_md_start, w_bubble;

  assign w_src_a      = fwd_sel(ForwardAE, RD1E, ResultW, r_alu_out_m);
  assign w_write_data = fwd_sel(ForwardBE, RD2E, ResultW, r_alu_out_m);
  assign w_src_b      = ALUSrcE ? SignImmE : w_write_data;

  always_comb begin
    w_alu = '0;
    case (ALUControlE)
      ALU_AND:  w_alu = w_src_a & w_src_b;
      ALU_OR:   w_alu = w_src_a | w_src_b;
      ALU_ADD:  w_alu = w_src_a + w_src_b;
      ALU_XOR:  w_alu = w_src_a ^ w_src_b;
      ALU_NOR:  w_alu = ~(w_src_a | w_src_b);
      ALU_SLTU: w_alu = {31'd0, w_src_a < w_src_b};
      ALU_SUB:  w_alu = w_src_a - w_src_b;
      ALU_SLT:  w_alu = {31'd0, $signed(w_src_a) < $signed(w_src_b)};
      default:  w_alu = '0;
    endcase
  end

  assign w_result = (MulDivE == MD_MFHI) ? w_hi :
                    (MulDivE == MD_MFLO) ? w_lo : w_alu;

  // Any HI/LO access waits for the unit; a flushed op is never started.
  assign StallE     = w_busy & is_md_any(MulDivE);
  assign w_md_start = is_md_arith(MulDivE) & ~w_busy & ~FlushE;
  assign w_bubble   = StallE | FlushE;

  muldiv_unit u_muldiv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (w_md_start),
    .op    (MulDivE),
    .a     (w_src_a),
    .b     (w_write_data),
    .busy  (w_busy),
    .hi    (w_hi),
    .lo    (w_lo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reg_write_m  <= 1'b0;
      r_memto_reg_m  <= 1'b0;
      r_mem_write_m  <= 1'b0;
      r_write_reg_m  <= '0;
      r_alu_out_m    <= '0;
      r_write_data_m <= '0;
    end else begin
      r_reg_write_m  <= RegWriteE & ~w_bubble;
      r_memto_reg_m  <= MemtoRegE & ~w_bubble;
      r_mem_write_m  <= MemWriteE & ~w_bubble;
      r_write_reg_m  <= RegDstE ? RdE : RtE;
      r_alu_out_m    <= w_result;
      r_write_data_m <= w_write_data;
    end
  end

  assign RegWriteM  = r_reg_write_m;
  assign MemtoRegM  = r_memto_reg_m;
  assign MemWriteM  = r_mem_write_m;
  assign WriteRegM  = r_write_reg_m;
  assign ALUOutM    = r_alu_out_m;
  assign WriteDataM = r_write_data_m;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU/forwarding vector table plus hand-built
// mul/div, stall, flush and reset sequences.
module tb_ex_stage;
  import mips_pkg::*;

  logic        clk, rst_n;
  logic        RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, FlushE;
  logic [2:0]  ALUControlE, MulDivE;
  logic [4:0]  RtE, RdE;
  logic [31:0] RD1E, RD2E, SignImmE, ResultW;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        RegWriteM, MemtoRegM, MemWriteM, StallE;
  logic [4:0]  WriteRegM;
  logic [31:0] ALUOutM, WriteDataM;

  ex_stage dut (
    .clk(clk), .rst_n(rst_n),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
    .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE), .RegDstE(RegDstE), .MulDivE(MulDivE),
    .RtE(RtE), .RdE(RdE), .RD1E(RD1E), .RD2E(RD2E), .SignImmE(SignImmE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW), .FlushE(FlushE),
    .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
    .WriteRegM(WriteRegM), .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .StallE(StallE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [2:0]  alu;
    logic        src, dst;
    logic [1:0]  fa, fb;
    logic [31:0] rd1, rd2, imm, resw;
    logic [4:0]  rt, rd;
    logic        rw, m2r, mw;
    logic [31:0] e_alu, e_wd;
    logic [4:0]  e_wr;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_nop();
    RegWriteE = 0; MemtoRegE = 0; MemWriteE = 0; ALUSrcE = 0; RegDstE = 0; FlushE = 0;
    ALUControlE = ALU_ADD; MulDivE = MD_NONE; RtE = '0; RdE = '0;
    RD1E = '0; RD2E = '0; SignImmE = '0; ResultW = '0; ForwardAE = FWD_RD; ForwardBE = FWD_RD;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_rw"},   32'(RegWriteM), 32'd0);
    chk({nm, "_m2r"},  32'(MemtoRegM), 32'd0);
    chk({nm, "_mw"},   32'(MemWriteM), 32'd0);
    chk({nm, "_wreg"}, 32'(WriteRegM), 32'd0);
    chk({nm, "_alu"},  ALUOutM, 32'd0);
    chk({nm, "_wd"},   WriteDataM, 32'd0);
    chk({nm, "_stall"}, 32'(StallE), 32'd0);
  endtask

  task automatic issue_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    set_nop();
    MulDivE = op; RD1E = a; RD2E = b;
    tick();
    set_nop();
  endtask

  // Presents MFHI/MFLO, counts stall cycles, then checks the moved value.
  task automatic run_mf(input logic [2:0] op, input int exp_stalls, input logic [31:0] exp_val,
                        input string nm);
    int stalls;
    logic bub_bad;
    set_nop();
    MulDivE = op; RegWriteE = 1; RegDstE = 1; RdE = 5'd8;
    #1;
    stalls = 0;
    bub_bad = 0;
    while (StallE === 1'b1 && stalls < 200) begin
      tick();
      stalls++;
      if (RegWriteM !== 1'b0 || MemWriteM !== 1'b0 || MemtoRegM !== 1'b0) bub_bad = 1;
    end
    chk({nm, "_stalls"}, 32'(stalls), 32'(exp_stalls));
    if (exp_stalls > 0) chk({nm, "_bubble"}, 32'(bub_bad), 32'd0);
    tick();
    chk(nm, ALUOutM, exp_val);
    chk({nm, "_wreg"}, 32'(WriteRegM), 32'd8);
    chk({nm, "_rw"}, 32'(RegWriteM), 32'd1);
    set_nop();
  endtask

  initial begin
    //          alu       src dst fa       fb       rd1            rd2            imm    resw        rt  rd  rw m2r mw  e_alu          e_wd           e_wr
    vecs[0]  = '{ALU_AND,  0, 1, FWD_RD,   FWD_RD,   32'hF0F0_00FF, 32'h0FF0_0F0F, 32'd0, 32'd0,     3,  7,  1, 0, 0, 32'h00F0_000F, 32'h0FF0_0F0F, 7};
    vecs[1]  = '{ALU_OR,   0, 1, FWD_RD,   FWD_RD,   32'hF0F0_00FF, 32'h0FF0_0F0F, 32'd0, 32'd0,     3,  7,  1, 0, 0, 32'hFFF0_0FFF, 32'h0FF0_0F0F, 7};
    vecs[2]  = '{ALU_ADD,  0, 0, FWD_RD,   FWD_RD,   32'hFFFF_FFFF, 32'd1,         32'd0, 32'd0,     4,  9,  1, 0, 0, 32'd0,         32'd1,         4};
    vecs[3]  = '{ALU_SUB,  0, 0, FWD_RD,   FWD_RD,   32'd3,         32'd5,         32'd0, 32'd0,     5,  9,  1, 0, 0, 32'hFFFF_FFFE, 32'd5,         5};
    vecs[4]  = '{ALU_SLT,  0, 1, FWD_RD,   FWD_RD,   32'hFFFF_FFFF, 32'd1,         32'd0, 32'd0,     0,  10, 1, 0, 0, 32'd1,         32'd1,         10};
    vecs[5]  = '{ALU_SLTU, 0, 1, FWD_RD,   FWD_RD,   32'hFFFF_FFFF, 32'd1,         32'd0, 32'd0,     0,  10, 1, 0, 0, 32'd0,         32'd1,         10};
    vecs[6]  = '{ALU_XOR,  0, 1, FWD_RD,   FWD_RD,   32'hA5A5_A5A5, 32'hFFFF_0000, 32'd0, 32'd0,     6,  11, 1, 0, 0, 32'h5A5A_A5A5, 32'hFFFF_0000, 11};
    vecs[7]  = '{ALU_NOR,  0, 1, FWD_RD,   FWD_RD,   32'h0000_FFFF, 32'h00FF_0000, 32'd0, 32'd0,     6,  11, 1, 0, 0, 32'hFF00_0000, 32'h00FF_0000, 11};
    vecs[8]  = '{ALU_ADD,  1, 0, FWD_RD,   FWD_RD,   32'd3,         32'h0000_DEAD, 32'd4, 32'd0,     12, 1,  0, 0, 1, 32'd7,         32'h0000_DEAD, 12};
    vecs[9]  = '{ALU_ADD,  1, 0, FWD_ALUM, FWD_RD,   32'd5,         32'd0,         32'd3, 32'd0,     13, 1,  1, 1, 0, 32'd10,        32'd0,         13};
    vecs[10] = '{ALU_ADD,  0, 0, FWD_RD,   FWD_RESW, 32'h20,        32'hBAD,       32'd0, 32'h100,   14, 1,  1, 0, 0, 32'h120,       32'h100,       14};
    vecs[11] = '{ALU_SUB,  0, 0, 2'b11,    FWD_RD,   32'd9,         32'd1,         32'd0, 32'h55,    15, 1,  1, 0, 0, 32'd8,         32'd1,         15};
    vecs[12] = '{ALU_SUB,  0, 0, FWD_RD,   FWD_RD,   32'h8000_0000, 32'd1,         32'd0, 32'd0,     16, 1,  1, 0, 0, 32'h7FFF_FFFF, 32'd1,         16};
    vecs[13] = '{ALU_ADD,  1, 0, FWD_RD,   FWD_ALUM, 32'd1,         32'd0,         32'd1, 32'd0,     17, 1,  0, 0, 1, 32'd2,         32'h7FFF_FFFF, 17};
    vecs[14] = '{ALU_SLT,  0, 0, FWD_RD,   FWD_RD,   32'h8000_0000, 32'h7FFF_FFFF, 32'd0, 32'd0,     18, 1,  1, 0, 0, 32'd1,         32'h7FFF_FFFF, 18};
    vecs[15] = '{ALU_SLTU, 0, 0, FWD_RD,   FWD_RD,   32'h8000_0000, 32'h7FFF_FFFF, 32'd0, 32'd0,     19, 1,  1, 0, 0, 32'd0,         32'h7FFF_FFFF, 19};

    set_nop();
    rst_n = 1'b0;
    #1;
    chk_all_zero("reset");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    #1;

    for (int i = 0; i < NV; i++) begin
      set_nop();
      ALUControlE = vecs[i].alu; ALUSrcE = vecs[i].src; RegDstE = vecs[i].dst;
      ForwardAE = vecs[i].fa; ForwardBE = vecs[i].fb;
      RD1E = vecs[i].rd1; RD2E = vecs[i].rd2; SignImmE = vecs[i].imm; ResultW = vecs[i].resw;
      RtE = vecs[i].rt; RdE = vecs[i].rd;
      RegWriteE = vecs[i].rw; MemtoRegE = vecs[i].m2r; MemWriteE = vecs[i].mw;
      tick();
      chk($sformatf("v%0d_alu", i),  ALUOutM, vecs[i].e_alu);
      chk($sformatf("v%0d_wd", i),   WriteDataM, vecs[i].e_wd);
      chk($sformatf("v%0d_wreg", i), 32'(WriteRegM), 32'(vecs[i].e_wr));
      chk($sformatf("v%0d_ctl", i),  {29'd0, RegWriteM, MemtoRegM, MemWriteM},
          {29'd0, vecs[i].rw, vecs[i].m2r, vecs[i].mw});
    end

    issue_md(MD_MULT, 32'hFFFF_FFFF, 32'd2);
    run_mf(MD_MFHI, 33, 32'hFFFF_FFFF, "mult_hi");
    run_mf(MD_MFLO, 0,  32'hFFFF_FFFE, "mult_lo");

    issue_md(MD_MULTU, 32'hFFFF_FFFF, 32'd2);
    run_mf(MD_MFHI, 33, 32'd1,         "multu_hi");
    run_mf(MD_MFLO, 0,  32'hFFFF_FFFE, "multu_lo");

    issue_md(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    run_mf(MD_MFLO, 33, 32'hFFFF_FFFD, "div_lo");
    run_mf(MD_MFHI, 0,  32'hFFFF_FFFF, "div_hi");

    issue_md(MD_DIVU, 32'd9, 32'd0);
    run_mf(MD_MFLO, 33, 32'hFFFF_FFFF, "divz_lo");
    run_mf(MD_MFHI, 0,  32'd9,         "divz_hi");

    // Back-to-back: the DIV waits out the whole MULT before being accepted.
    begin
      int stalls;
      issue_md(MD_MULT, 32'd3, 32'd4);
      MulDivE = MD_DIV; RD1E = 32'd100; RD2E = 32'd7;
      #1;
      stalls = 0;
      while (StallE === 1'b1 && stalls < 200) begin
        tick();
        stalls++;
      end
      chk("b2b_div_stalls", 32'(stalls), 32'd33);
      tick();
      set_nop();
      run_mf(MD_MFLO, 33, 32'd14, "b2b_lo");
      run_mf(MD_MFHI, 0,  32'd2,  "b2b_hi");
    end

    // Flush while stalled: one bubble per cycle, running op undisturbed.
    issue_md(MD_MULTU, 32'd6, 32'd7);
    for (int k = 0; k < 3; k++) begin
      set_nop();
      MulDivE = MD_MULTU; RD1E = 32'd1; RD2E = 32'd1; RegWriteE = 1; MemWriteE = 1; FlushE = 1;
      #1;
      chk($sformatf("flush_stall%0d", k), 32'(StallE), 32'd1);
      tick();
      chk($sformatf("flush_bubble%0d", k), {30'd0, RegWriteM, MemWriteM}, 32'd0);
    end
    run_mf(MD_MFLO, 30, 32'd42, "flush_lo");
    run_mf(MD_MFHI, 0,  32'd0,  "flush_hi");
    tick();
    chk("no_dup_rw", 32'(RegWriteM), 32'd0);

    // A flushed MULT while idle must not start the unit.
    set_nop();
    MulDivE = MD_MULT; RD1E = 32'd5; RD2E = 32'd5; RegWriteE = 1; FlushE = 1;
    #1;
    chk("flush_idle_stall", 32'(StallE), 32'd0);
    tick();
    chk("flush_idle_rw", 32'(RegWriteM), 32'd0);
    run_mf(MD_MFLO, 0, 32'd42, "flush_nostart_lo");

    // ALU traffic proceeds while busy; reset mid-RUN clears everything.
    issue_md(MD_MULT, 32'd5, 32'd5);
    ALUControlE = ALU_ADD; RD1E = 32'h1234; RD2E = 32'd1;
    RegWriteE = 1; MemtoRegE = 1; MemWriteE = 1; RegDstE = 1; RdE = 5'd31;
    repeat (5) tick();
    chk("busy_alu", ALUOutM, 32'h1235);
    chk("busy_ctl", {29'd0, RegWriteM, MemtoRegM, MemWriteM}, 32'd7);
    set_nop();
    MulDivE = MD_MFLO;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrun_rst");
    @(posedge clk);
    #3 rst_n = 1'b1;
    run_mf(MD_MFLO, 0, 32'd0, "rst_lo");
    run_mf(MD_MFHI, 0, 32'd0, "rst_hi");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
